// File: rtl/hello_scroller.sv
// Scrolling seven-segment message display: a writable character buffer viewed
// through an N_DIGITS-wide window whose offset advances on prescaler ticks or manual steps.
module hello_scroller #(
    parameter int N_DIGITS = 8,
    parameter int MSG_LEN  = 8,
    parameter int TICK_DIV = 50000000,
    parameter int AW       = $clog2(MSG_LEN)
) (
    input  logic                  CLOCK_50,
    input  logic                  RESETn,
    input  logic                  RUN,
    input  logic                  DIR,
    input  logic                  STEP,
    input  logic                  WR_EN,
    input  logic [AW-1:0]         WR_ADDR,
    input  logic [4:0]            WR_CHAR,
    output logic [7*N_DIGITS-1:0] HEX,
    output logic [AW-1:0]         POS,
    output logic                  TICK
);

    localparam int PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
    localparam logic [AW-1:0] OFF_LAST = AW'(MSG_LEN - 1);
    // Wide enough to hold offset + (N_DIGITS-1) before the modulo.
    localparam int IW = AW + 4;

    logic [PW-1:0]         pre_cnt_reg;
    logic [AW-1:0]         offset_reg;
    logic [AW-1:0]         offset_next;
    logic                  step_reg;
    logic                  step_rise;
    logic                  advance;
    logic [4:0]            buffer_reg [MSG_LEN];
    logic [7*N_DIGITS-1:0] hex_reg;
    logic [7*N_DIGITS-1:0] hex_next;

    function automatic logic [4:0] init_char(input int idx);
        logic [4:0] c;
        case (idx)
            0:       c = 5'h10;
            1:       c = 5'h0E;
            2:       c = 5'h11;
            3:       c = 5'h11;
            4:       c = 5'h00;
            default: c = 5'h13;
        endcase
        return c;
    endfunction

    function automatic logic [6:0] seg_decode(input logic [4:0] ch);
        logic [6:0] s;
        case (ch)
            5'h00:   s = 7'b0000001;
            5'h01:   s = 7'b1001111;
            5'h02:   s = 7'b0010010;
            5'h03:   s = 7'b0000110;
            5'h04:   s = 7'b1001100;
            5'h05:   s = 7'b0100100;
            5'h06:   s = 7'b0100000;
            5'h07:   s = 7'b0001111;
            5'h08:   s = 7'b0000000;
            5'h09:   s = 7'b0000100;
            5'h0A:   s = 7'b0001000;
            5'h0B:   s = 7'b1100000;
            5'h0C:   s = 7'b0110001;
            5'h0D:   s = 7'b1000010;
            5'h0E:   s = 7'b0110000;
            5'h0F:   s = 7'b0111000;
            5'h10:   s = 7'b1001000;
            5'h11:   s = 7'b1110001;
            5'h12:   s = 7'b0011000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Free-running prescaler, independent of RUN.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            pre_cnt_reg <= '0;
        end else if (pre_cnt_reg == PRE_LAST) begin
            pre_cnt_reg <= '0;
        end else begin
            pre_cnt_reg <= pre_cnt_reg + 1'b1;
        end
    end

    assign TICK      = (pre_cnt_reg == PRE_LAST);
    assign step_rise = STEP & ~step_reg;
    assign advance   = RUN ? TICK : step_rise;

    always_comb begin
        offset_next = offset_reg;
        if (advance) begin
            if (!DIR) begin
                offset_next = (offset_reg == OFF_LAST) ? '0 : offset_reg + 1'b1;
            end else begin
                offset_next = (offset_reg == '0) ? OFF_LAST : offset_reg - 1'b1;
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            offset_reg <= '0;
            step_reg   <= 1'b0;
        end else begin
            offset_reg <= offset_next;
            step_reg   <= STEP;
        end
    end

    // Reset reloads the default message, so the buffer lives in flops.
    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            for (int a = 0; a < MSG_LEN; a++) begin
                buffer_reg[a] <= init_char(a);
            end
        end else if (WR_EN && (int'(WR_ADDR) < MSG_LEN)) begin
            buffer_reg[WR_ADDR] <= WR_CHAR;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [IW-1:0] sum;
            logic [AW-1:0] idx;
            assign sum = {4'b0000, offset_reg} + IW'(N_DIGITS - 1 - gi);
            assign idx = AW'(sum % IW'(MSG_LEN));
            assign hex_next[7*gi +: 7] = seg_decode(buffer_reg[idx]);
        end
    endgenerate

    always_ff @(posedge CLOCK_50 or negedge RESETn) begin
        if (!RESETn) begin
            hex_reg <= '1;
        end else begin
            hex_reg <= hex_next;
        end
    end

    assign HEX = hex_reg;
    assign POS = offset_reg;

endmodule

// File: tb/tb_hello_scroller.sv
// Randomized self-checking bench for hello_scroller; an 8-char and a 6-char
// instance share stimulus and are compared against a window-level model.
module tb_hello_scroller;

    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run = 1'b0;
    logic        dir = 1'b0;
    logic        step = 1'b0;
    logic        wr_en = 1'b0;
    logic [2:0]  wr_addr = '0;
    logic [4:0]  wr_char = '0;
    logic [55:0] hex8, hex6;
    logic [2:0]  pos8, pos6;
    logic        tick8, tick6;

    always #5 clk = ~clk;

    hello_scroller #(.N_DIGITS(8), .MSG_LEN(8), .TICK_DIV(TD)) dut8 (
        .CLOCK_50(clk), .RESETn(rst_n), .RUN(run), .DIR(dir), .STEP(step),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_CHAR(wr_char),
        .HEX(hex8), .POS(pos8), .TICK(tick8)
    );

    hello_scroller #(.N_DIGITS(8), .MSG_LEN(6), .TICK_DIV(TD)) dut6 (
        .CLOCK_50(clk), .RESETn(rst_n), .RUN(run), .DIR(dir), .STEP(step),
        .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_CHAR(wr_char),
        .HEX(hex6), .POS(pos6), .TICK(tick6)
    );

    int checks = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [6:0] glyph_of(input int c);
        case (c)
            0:  return 7'b0000001;  1:  return 7'b1001111;
            2:  return 7'b0010010;  3:  return 7'b0000110;
            4:  return 7'b1001100;  5:  return 7'b0100100;
            6:  return 7'b0100000;  7:  return 7'b0001111;
            8:  return 7'b0000000;  9:  return 7'b0000100;
            10: return 7'b0001000;  11: return 7'b1100000;
            12: return 7'b0110001;  13: return 7'b1000010;
            14: return 7'b0110000;  15: return 7'b0111000;
            16: return 7'b1001000;  17: return 7'b1110001;
            18: return 7'b0011000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Model: message contents, offset, expected registered display, edges since release.
    int          mlen [2] = '{8, 6};
    int          mbuf [2][8];
    int          moff [2];
    logic [55:0] mhex [2];
    int          edges;
    bit          mhist;

    function automatic logic [55:0] window(input int k);
        logic [55:0] w;
        for (int i = 0; i < 8; i++) begin
            w[7*i +: 7] = glyph_of(mbuf[k][(moff[k] + 7 - i) % mlen[k]]);
        end
        return w;
    endfunction

    task automatic model_reset();
        int hello [5] = '{16, 14, 17, 17, 0};
        for (int k = 0; k < 2; k++) begin
            for (int a = 0; a < 8; a++) mbuf[k][a] = (a < 5) ? hello[a] : 19;
            moff[k] = 0;
            mhex[k] = '1;
        end
        edges = 0;
        mhist = 1'b0;
    endtask

    task automatic cycle();
        bit tick_now, adv;
        @(posedge clk);
        if (rst_n) begin
            tick_now = (edges % TD) == TD - 1;
            adv = run ? tick_now : (step && !mhist);
            for (int k = 0; k < 2; k++) begin
                mhex[k] = window(k);
                if (adv) moff[k] = dir ? (moff[k] + mlen[k] - 1) % mlen[k] : (moff[k] + 1) % mlen[k];
                if (wr_en && int'(wr_addr) < mlen[k]) mbuf[k][wr_addr] = int'(wr_char);
            end
            mhist = step;
            edges++;
        end
        #1;
        check_val("pos8", 64'(pos8), 64'(moff[0]));
        check_val("pos6", 64'(pos6), 64'(moff[1]));
        check_val("hex8", 64'(hex8), 64'(mhex[0]));
        check_val("hex6", 64'(hex6), 64'(mhex[1]));
        check_val("tick8", 64'(tick8), 64'((edges % TD) == TD - 1));
        check_val("tick6", 64'(tick6), 64'((edges % TD) == TD - 1));
    endtask

    initial begin
        int start, ticks_seen, guard;
        logic [55:0] saved;

        // Reset and first window
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_hex8", 64'(hex8), 64'({56{1'b1}}));
        check_val("rst_pos8", 64'(pos8), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check_val("hello_dig7", 64'(hex8[55:49]), 64'(7'b1001000));
        check_val("hello_dig0", 64'(hex8[6:0]), 64'(7'b1111111));
        $display("txn reset_release pos=%0d hex=%014h", pos8, hex8);

        // Writes: 'P' to slot 5, then out-of-range slot 7 on the 6-char instance
        wr_en = 1'b1; wr_addr = 3'd5; wr_char = 5'h12;
        cycle();
        wr_en = 1'b0;
        cycle();
        check_val("write_dig2", 64'(hex8[20:14]), 64'(7'b0011000));
        saved = hex6;
        wr_en = 1'b1; wr_addr = 3'd7; wr_char = 5'h08;
        cycle();
        wr_en = 1'b0;
        cycle();
        check_val("oob_write6", 64'(hex6), 64'(saved));
        $display("txn writes hex8=%014h hex6=%014h", hex8, hex6);

        // Auto-scroll left for a full lap
        run = 1'b1; dir = 1'b0;
        start = moff[0];
        ticks_seen = 0;
        repeat (32) begin
            cycle();
            if (tick8) ticks_seen++;
        end
        check_val("lap_pos", 64'(pos8), 64'(start));
        check_val("lap_ticks", 64'(ticks_seen), 64'd8);
        $display("txn run_left pos=%0d ticks=%0d", pos8, ticks_seen);

        // Scroll right
        dir = 1'b1;
        repeat (8) cycle();
        $display("txn run_right pos=%0d", pos8);

        // Held STEP while paused advances once
        run = 1'b0; dir = 1'b0;
        cycle();
        start = moff[0];
        step = 1'b1;
        repeat (10) cycle();
        step = 1'b0;
        cycle();
        check_val("step_once", 64'(pos8), 64'((start + 1) % 8));
        $display("txn step_hold pos=%0d", pos8);

        // Randomized traffic
        repeat (250) begin
            run     = ($urandom_range(0, 2) == 0);
            dir     = 1'($urandom_range(0, 1));
            step    = 1'($urandom_range(0, 1));
            wr_en   = ($urandom_range(0, 4) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_char = 5'($urandom_range(0, 31));
            cycle();
        end
        wr_en = 1'b0; step = 1'b0; run = 1'b0; dir = 1'b0;
        cycle();
        $display("txn random pos8=%0d pos6=%0d", pos8, pos6);

        // Step to offset 3, write, then reset mid-cycle
        guard = 0;
        while (moff[0] != 3 && guard < 20) begin
            step = 1'b1; cycle();
            step = 1'b0; cycle();
            guard++;
        end
        check_val("reach_pos3", 64'(pos8), 64'd3);
        wr_en = 1'b1; wr_addr = 3'd0; wr_char = 5'h0A;
        cycle();
        wr_en = 1'b0;
        cycle();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_val("async_hex8", 64'(hex8), 64'({56{1'b1}}));
        check_val("async_pos8", 64'(pos8), 64'd0);
        check_val("async_hex6", 64'(hex6), 64'({56{1'b1}}));
        check_val("async_pos6", 64'(pos6), 64'd0);
        model_reset();
        cycle();
        @(negedge clk) rst_n = 1'b1;
        cycle();
        check_val("rehello_dig7", 64'(hex8[55:49]), 64'(7'b1001000));
        check_val("rehello_dig3", 64'(hex8[27:21]), 64'(7'b0000001));
        $display("txn mid_reset pos=%0d hex=%014h", pos8, hex8);
        repeat (8) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
